// File: rtl/serial_mag_compare.sv
// Bit-serial MSB-first unsigned comparator; result one-hot on C/D/E with done pulse in cycle WIDTH+1.
// start is ignored while busy; define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit.
module serial_mag_compare #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             C,
    output logic             D,
    output logic             E
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             decided, res_gt, res_lt;
    logic             gt_bit, eq_bit, lt_bit;
    logic             nxt_gt, nxt_lt;

    assign gt_bit = sa[WIDTH-1] & ~sb[WIDTH-1];
    assign eq_bit = ~(sa[WIDTH-1] ^ sb[WIDTH-1]);
    assign lt_bit = ~sa[WIDTH-1] & sb[WIDTH-1];

    // Only the first differing bit decides; later bits pass through unused.
    assign nxt_gt = decided ? res_gt : gt_bit;
    assign nxt_lt = decided ? res_lt : lt_bit;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (cnt == '0) state_nxt = DONE;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (!decided && !eq_bit) state_nxt = DONE;
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            res_gt  <= 1'b0;
            res_lt  <= 1'b0;
            C       <= 1'b0;
            D       <= 1'b0;
            E       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa      <= A;
                    sb      <= B;
                    cnt     <= CNT_INIT;
                    decided <= 1'b0;
                    res_gt  <= 1'b0;
                    res_lt  <= 1'b0;
                    C       <= 1'b0;
                    D       <= 1'b0;
                    E       <= 1'b0;
                end
                RUN: begin
                    sa      <= sa << 1;
                    sb      <= sb << 1;
                    cnt     <= cnt - 1'b1;
                    decided <= decided | ~eq_bit;
                    res_gt  <= nxt_gt;
                    res_lt  <= nxt_lt;
                    // Publish the result as DONE is entered so it is valid with done.
                    if (state_nxt == DONE) begin
                        C <= nxt_gt;
                        D <= ~(nxt_gt | nxt_lt);
                        E <= nxt_lt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
